// File: rtl/encrypter_output_sequencer.sv
// Round-robin collector that serialises encrypter results onto the QSPI return path, LSB nibble first.
// Optional stalled-encrypter skip is built when SEQ_TIMEOUT_EN is defined.
module encrypter_output_sequencer #(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      stream_start,
  input  logic [NUM_ENCRYPTERS-1:0]                 enc_valid,
  input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_data,
  output logic [NUM_ENCRYPTERS-1:0]                 enc_ack,
  output logic [3:0]                                qspi_out_data,
  output logic                                      qspi_out_valid,
  input  logic                                      qspi_out_ready,
  output logic                                      busy,
  output logic [$clog2(NUM_ENCRYPTERS)-1:0]         cur_index,
  output logic [15:0]                               packets_sent,
  output logic                                      timeout_err
);

  localparam int PW = $clog2(NUM_ENCRYPTERS);
  localparam int W = ENCRYPTER_WIDTH;
  localparam int NIBBLES = W / 4;
  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [NUM_ENCRYPTERS-1:0] ONE = 1;

  typedef enum logic {ST_WAIT, ST_SHIFT} state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [NW-1:0]             nib_q, nib_d;
  logic [W-1:0]              shreg_q, shreg_d;
  logic                      pend_q, pend_d;
  logic [15:0]               pkt_q, pkt_d;
  logic [NUM_ENCRYPTERS-1:0] ack_q, ack_d;
  logic [W-1:0]              sel_data;
  logic                      sel_valid;
  logic [PW-1:0]             ptr_inc;
  logic                      tmo_hit;

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WW-1:0] wait_q, wait_d;

  assign tmo_hit = (state_q == ST_WAIT) && !stream_start &&
                   !sel_valid && (wait_q == WW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
      if (ptr_q == PW'(i)) sel_data = enc_data[i*W +: W];
    end
  end

  assign sel_valid = enc_valid[ptr_q];
  assign ptr_inc = (ptr_q == PW'(NUM_ENCRYPTERS - 1)) ? '0 : ptr_q + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      ptr_q   <= '0;
      nib_q   <= '0;
      shreg_q <= '0;
      pend_q  <= 1'b0;
      pkt_q   <= '0;
      ack_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      nib_q   <= nib_d;
      shreg_q <= shreg_d;
      pend_q  <= pend_d;
      pkt_q   <= pkt_d;
      ack_q   <= ack_d;
`ifdef SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    nib_d   = nib_q;
    shreg_d = shreg_q;
    pend_d  = pend_q;
    pkt_d   = pkt_q;
    ack_d   = '0;
`ifdef SEQ_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    unique case (state_q)
      ST_WAIT: begin
        if (stream_start) begin
          ptr_d = '0;
          pkt_d = '0;
`ifdef SEQ_TIMEOUT_EN
          wait_d = '0;
`endif
        end else if (sel_valid) begin
          shreg_d = sel_data;
          nib_d   = '0;
          ack_d   = ONE << ptr_q;
          state_d = ST_SHIFT;
        end else if (tmo_hit) begin
          ptr_d = ptr_inc;
`ifdef SEQ_TIMEOUT_EN
          wait_d = '0;
`endif
        end else begin
`ifdef SEQ_TIMEOUT_EN
          wait_d = wait_q + WW'(1);
`endif
        end
      end
      ST_SHIFT: begin
        if (stream_start) pend_d = 1'b1;
        if (qspi_out_ready) begin
          shreg_d = shreg_q >> 4;
          nib_d   = nib_q + NW'(1);
          if (nib_q == NW'(NIBBLES - 1)) begin
            state_d = ST_WAIT;
            nib_d   = '0;
`ifdef SEQ_TIMEOUT_EN
            wait_d  = '0;
`endif
            // A start seen during the packet restarts the stream once it is out
            if (pend_q || stream_start) begin
              ptr_d  = '0;
              pkt_d  = '0;
              pend_d = 1'b0;
            end else begin
              ptr_d = ptr_inc;
              pkt_d = pkt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    qspi_out_valid = (state_q == ST_SHIFT);
    busy           = (state_q == ST_SHIFT);
    qspi_out_data  = shreg_q[3:0];
    enc_ack        = ack_q;
    cur_index      = ptr_q;
    packets_sent   = pkt_q;
    timeout_err    = tmo_hit;
  end

endmodule

// File: tb/tb_encrypter_output_sequencer.sv
// Directed bench for encrypter_output_sequencer: ordering, nibble serialisation, restart and reset.
// Build with SEQ_TIMEOUT_EN to also exercise the stalled-encrypter skip.
module tb_encrypter_output_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         stream_start;
  logic [3:0]   enc_valid;
  logic [127:0] enc_data;
  logic [3:0]   enc_ack;
  logic [3:0]   qd;
  logic         qv;
  logic         qr;
  logic         busy;
  logic [1:0]   cur_index;
  logic [15:0]  packets_sent;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail = 0;

`ifdef SEQ_TIMEOUT_EN
  localparam int IDLE_CYC = 12;
`else
  localparam int IDLE_CYC = 50;
`endif

  encrypter_output_sequencer #(
    .NUM_ENCRYPTERS(4),
    .ENCRYPTER_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stream_start(stream_start),
    .enc_valid(enc_valid),
    .enc_data(enc_data),
    .enc_ack(enc_ack),
    .qspi_out_data(qd),
    .qspi_out_valid(qv),
    .qspi_out_ready(qr),
    .busy(busy),
    .cur_index(cur_index),
    .packets_sent(packets_sent),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stream_start = 1'b0;
    enc_valid = '0;
    enc_data = '0;
    qr = 1'b1;
    #3;
    n_checks++;
    if ({qv, busy, enc_ack, qd, timeout_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%0b b=%0b ack=%b d=%h t=%0b want all 0",
               qv, busy, enc_ack, qd, timeout_err);
    end
    n_checks++;
    if (cur_index !== 2'd0 || packets_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counts got idx=%0d pkts=%0d want 0 0", cur_index, packets_sent);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    enc_data[31:0] = 32'h8765_4321;
    enc_valid = 4'b0001;
    qr = 1'b1;
    step();
    n_checks++;
    if (enc_ack !== 4'b0001 || qv !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_load got ack=%b v=%0b b=%0b want 0001 1 1", enc_ack, qv, busy);
    end
    enc_valid = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (qv !== 1'b1 || qd !== 4'(k + 1)) begin
        n_fail++;
        $display("FAIL single_nibble%0d got v=%0b d=%h want 1 %h", k, qv, qd, k + 1);
      end
      if (k == 1) begin
        n_checks++;
        if (enc_ack !== 4'b0000) begin
          n_fail++;
          $display("FAIL single_ack_pulse got %b want 0000", enc_ack);
        end
      end
      step();
    end
    n_checks++;
    if (qv !== 1'b0 || busy !== 1'b0 || cur_index !== 2'd1 || packets_sent !== 16'd1) begin
      n_fail++;
      $display("FAIL single_end got v=%0b b=%0b idx=%0d pkts=%0d want 0 0 1 1",
               qv, busy, cur_index, packets_sent);
    end
  endtask

  task automatic test_wait_ptr();
    logic [31:0] d;
    d = 32'hA5C3_1E90;
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    n_checks++;
    if (cur_index !== 2'd0 || packets_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL wait_restart got idx=%0d pkts=%0d want 0 0", cur_index, packets_sent);
    end
    enc_data[95:64] = 32'hDEAD_BEEF;
    enc_valid = 4'b0100;
    for (int k = 0; k < IDLE_CYC; k++) begin
      step();
      n_checks++;
      if (enc_ack !== 4'b0000 || qv !== 1'b0 || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_idle%0d got ack=%b v=%0b t=%0b want 0000 0 0",
                 k, enc_ack, qv, timeout_err);
      end
    end
    enc_data[31:0] = d;
    enc_valid = 4'b0101;
    step();
    n_checks++;
    if (enc_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL wait_first got ack=%b want 0001", enc_ack);
    end
    enc_valid = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (qd !== d[4*k +: 4]) begin
        n_fail++;
        $display("FAIL wait_nibble%0d got %h want %h", k, qd, d[4*k +: 4]);
      end
      step();
    end
    n_checks++;
    if (cur_index !== 2'd1 || packets_sent !== 16'd1) begin
      n_fail++;
      $display("FAIL wait_end got idx=%0d pkts=%0d want 1 1", cur_index, packets_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pk [4];
    int cnt;
    int cyc;
    logic tog;
    pk[0] = 32'h0123_4567;
    pk[1] = 32'h89AB_CDEF;
    pk[2] = 32'hF0E1_D2C3;
    pk[3] = 32'h1357_9BDF;
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      enc_data[p*32 +: 32] = pk[p];
      enc_valid = 4'b0001 << p;
      step();
      n_checks++;
      if (enc_ack !== (4'b0001 << p) || cur_index !== 2'(p)) begin
        n_fail++;
        $display("FAIL b2b_load%0d got ack=%b idx=%0d want %b %0d",
                 p, enc_ack, cur_index, 4'b0001 << p, p);
      end
      enc_valid = 4'b0000;
      cnt = 0;
      cyc = 0;
      tog = 1'b1;
      while (cnt < 8 && cyc < 40) begin
        n_checks++;
        if (qv !== 1'b1 || qd !== pk[p][4*cnt +: 4]) begin
          n_fail++;
          $display("FAIL b2b_p%0d_n%0d got v=%0b d=%h want 1 %h",
                   p, cnt, qv, qd, pk[p][4*cnt +: 4]);
        end
        qr = tog;
        step();
        if (tog) cnt++;
        tog = !tog;
        cyc++;
      end
      n_checks++;
      if (cnt != 8 || qv !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_end%0d got nibbles=%0d v=%0b want 8 0", p, cnt, qv);
      end
    end
    qr = 1'b1;
    n_checks++;
    if (cur_index !== 2'd0 || packets_sent !== 16'd4) begin
      n_fail++;
      $display("FAIL b2b_wrap got idx=%0d pkts=%0d want 0 4", cur_index, packets_sent);
    end
  endtask

  task automatic test_stream_start();
    logic [31:0] d;
    d = 32'hCAFE_F00D;
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    enc_data[31:0] = 32'h1111_2222;
    enc_valid = 4'b0001;
    step();
    enc_valid = 4'b0000;
    repeat (8) step();
    n_checks++;
    if (cur_index !== 2'd1 || packets_sent !== 16'd1) begin
      n_fail++;
      $display("FAIL start_pre got idx=%0d pkts=%0d want 1 1", cur_index, packets_sent);
    end
    enc_data[63:32] = d;
    enc_valid = 4'b0010;
    step();
    n_checks++;
    if (enc_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL start_load got ack=%b want 0010", enc_ack);
    end
    enc_valid = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (qv !== 1'b1 || qd !== d[4*k +: 4]) begin
        n_fail++;
        $display("FAIL start_nibble%0d got v=%0b d=%h want 1 %h", k, qv, qd, d[4*k +: 4]);
      end
      stream_start = (k == 2);
      step();
    end
    stream_start = 1'b0;
    n_checks++;
    if (qv !== 1'b0 || cur_index !== 2'd0 || packets_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL start_end got v=%0b idx=%0d pkts=%0d want 0 0 0",
               qv, cur_index, packets_sent);
    end
  endtask

  task automatic test_async_reset();
    enc_data[31:0] = 32'h2468_ACE0;
    enc_valid = 4'b0001;
    step();
    enc_valid = 4'b0000;
    repeat (8) step();
    enc_data[63:32] = 32'h1357_2468;
    enc_valid = 4'b0010;
    step();
    enc_valid = 4'b0000;
    n_checks++;
    if (enc_ack !== 4'b0010 || qv !== 1'b1 || cur_index !== 2'd1) begin
      n_fail++;
      $display("FAIL areset_pre got ack=%b v=%0b idx=%0d want 0010 1 1", enc_ack, qv, cur_index);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (qv !== 1'b0 || busy !== 1'b0 || enc_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_drop got v=%0b b=%0b ack=%b want 0 0 0000", qv, busy, enc_ack);
    end
    n_checks++;
    if (cur_index !== 2'd0 || packets_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_state got idx=%0d pkts=%0d want 0 0", cur_index, packets_sent);
    end
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (enc_ack !== 4'b0000 || qv !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_noreack got ack=%b v=%0b want 0000 0", enc_ack, qv);
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int hit;
    reset = 1'b1;
    enc_valid = 4'b0000;
    step();
    reset = 1'b0;
    hit = -1;
    for (int k = 0; k < 40; k++) begin
      if (timeout_err === 1'b1) begin
        hit = k;
        break;
      end
      step();
    end
    n_checks++;
    if (hit != 15 || cur_index !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_cycle got cycle=%0d idx=%0d want 15 0", hit, cur_index);
    end
    step();
    n_checks++;
    if (timeout_err !== 1'b0 || cur_index !== 2'd1 || packets_sent !== 16'd0 ||
        enc_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_after got t=%0b idx=%0d pkts=%0d ack=%b want 0 1 0 0000",
               timeout_err, cur_index, packets_sent, enc_ack);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wait_ptr();
    test_back_to_back();
    test_stream_start();
    test_async_reset();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
